gray_colormap: RTL and testbench
================================

GRAY_COLORMAP -- requirements
Module: gray_colormap

Interface
REQ-001 SHALL have parameter PIPE_STAGES, default 2, meaning fixed pipeline depth; only value 2 is supported.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  gray sample present.
REQ-005 SHALL have port in_ready  output  1  block accepts sample this cycle.
REQ-006 SHALL have port gray_in  input  8  unsigned luminance.
REQ-007 SHALL have port in_sof  input  1  sample is first pixel of a frame.
REQ-008 SHALL have port mode_in  input  2  colormap select, sampled only with an accepted in_sof.
REQ-009 SHALL have port out_valid  output  1  RGB sample present.
REQ-010 SHALL have port out_ready  input  1  downstream accepts.
REQ-011 SHALL have port pixel_out  output  24  {R[23:16], G[15:8], B[7:0]}.
REQ-012 SHALL have port out_sof  output  1  in_sof delayed with its pixel.

Function
REQ-013 SHALL transfer on input when in_valid && in_ready, and on output when out_valid && out_ready.
REQ-014 SHALL be a 2-stage valid/ready pipeline: S1 registers gray, sof, and the effective mode; S2 registers the computed RGB and sof.
REQ-015 SHALL advance S2 when !v2 || out_ready, and S1 when !v1 || S2 advances; in_ready = !v1 || S2 advances (combinational from out_ready).
REQ-016 SHALL produce latency of exactly 2 cycles from accept to out_valid when out_ready is held high; throughput 1 pixel/cycle.
REQ-017 SHALL hold pixel_out, out_sof, and out_valid stable while out_valid && !out_ready; no sample dropped or duplicated.
REQ-018 SHALL latch mode_in into mode_reg on accept with in_sof=1; that pixel and all later pixels use the new mode until the next accepted sof.
REQ-019 SHALL ignore mode_in changes when in_sof=0 or when no transfer occurs.
REQ-020 SHALL, in mode 0 (gray), output R=G=B=g.
REQ-021 SHALL, in mode 1 (heat), output R=min(255,3g); G=0 if g<85 else min(255,3(g-85)); B=0 if g<170 else 3(g-170).
REQ-022 SHALL, in mode 2 (inverted), output R=G=B=255-g.
REQ-023 SHALL, in mode 3 (sepia), output R=g, G=(g*7)>>3, B=(g*5)>>3, truncating.
REQ-024 SHALL compute heat-map products in at least 10 bits, saturating before truncation to 8 bits; no wrap-around.
REQ-025 SHALL accept a new sample in the same cycle a full pipeline drains one (simultaneous in/out transfer).

Reset
REQ-026 SHALL clear v1, v2, out_valid, out_sof, pixel_out, and mode_reg (mode 0) asynchronously on rst_n low.
REQ-027 SHALL discard in-flight samples on reset mid-frame; in_ready = 1 the first cycle after release.
REQ-028 SHALL treat the first frame after reset as mode 0 until an sof is accepted.

Structure
REQ-029 SHALL place the colormap mode enum (CM_GRAY, CM_HEAT, CM_INV, CM_SEPIA) and the 85/170 breakpoint constants in shared package image_filter_pkg.
REQ-030 SHALL implement the per-pixel mapping as a combinational sub-module colormap_lut (gray + mode -> 24-bit RGB), instantiated between S1 and S2.

Verification
REQ-031 SHALL cover: mode 1, sof, g=0,84,85,128,170,255 with out_ready=1 -> pixel_out 000000, FC0000, FF0000, FF8100, FFFF00, FFFFFF, each 2 cycles after accept.
REQ-032 SHALL cover: mode 2 sof g=10, then mode_in=0 without sof, g=10 -> both outputs F5F5F5.
REQ-033 SHALL cover: out_ready low for 5 cycles with continuous input -> in_ready falls after 2 accepts; pixel_out is held; the sequence resumes in order with no loss.
REQ-034 SHALL cover: mode 3, g=200 -> pixel_out C8AF7D.
REQ-035 SHALL cover: rst_n pulsed with 2 samples in flight -> out_valid=0 immediately, and the next frame without sof uses mode 0.
REQ-036 SHALL cover: random in_valid/out_ready over 10k pixels -> scoreboard match against the reference mapping, and out_sof aligned with its pixel.

Source files
------------

// File: rtl/image_filter_pkg.sv
// Shared definitions for the image filter blocks: colormap selection
// codes, the heat-map breakpoints and a saturation helper.
package image_filter_pkg;

  typedef enum logic [1:0] {
    CM_GRAY  = 2'd0,
    CM_HEAT  = 2'd1,
    CM_INV   = 2'd2,
    CM_SEPIA = 2'd3
  } cm_mode_t;

  // Luminance levels where the heat map moves from red to yellow to white
  localparam logic [7:0] HEAT_BP_LOW  = 8'd85;
  localparam logic [7:0] HEAT_BP_HIGH = 8'd170;

  // Clamp a 10-bit intermediate product to the 8-bit channel range
  function automatic logic [7:0] sat8(input logic [9:0] value);
    return (value > 10'd255) ? 8'hFF : value[7:0];
  endfunction

endpackage

// File: rtl/colormap_lut.sv
// Combinational per-pixel mapping from an 8-bit luminance and a colormap
// select to a packed {R, G, B} colour.
module colormap_lut
  import image_filter_pkg::*;
(
  input  logic [7:0]  gray,
  input  logic [1:0]  mode,
  output logic [23:0] rgb
);

  logic [9:0] heat_r_full;
  logic [9:0] heat_g_full;
  logic [9:0] heat_b_full;
  logic [7:0] inv;
  logic [7:0] sepia_g;
  logic [7:0] sepia_b;

  // Heat products are formed at 10 bits and clamped, so they never wrap
  always_comb begin
    heat_r_full = 10'd3 * {2'b00, gray};
    heat_g_full = '0;
    heat_b_full = '0;
    if (gray >= HEAT_BP_LOW) begin
      heat_g_full = 10'd3 * {2'b00, 8'(gray - HEAT_BP_LOW)};
    end
    if (gray >= HEAT_BP_HIGH) begin
      heat_b_full = 10'd3 * {2'b00, 8'(gray - HEAT_BP_HIGH)};
    end
    inv     = 8'hFF - gray;
    sepia_g = 8'((11'd7 * {3'b000, gray}) >> 3);
    sepia_b = 8'((11'd5 * {3'b000, gray}) >> 3);
  end

  // Select the channel triple for the requested colormap
  always_comb begin
    rgb = {gray, gray, gray};
    case (cm_mode_t'(mode))
      CM_GRAY:  rgb = {gray, gray, gray};
      CM_HEAT:  rgb = {sat8(heat_r_full), sat8(heat_g_full), sat8(heat_b_full)};
      CM_INV:   rgb = {inv, inv, inv};
      CM_SEPIA: rgb = {gray, sepia_g, sepia_b};
      default:  rgb = {gray, gray, gray};
    endcase
  end

endmodule

// File: rtl/gray_colormap.sv
// Two-stage valid/ready pipeline turning a gray pixel stream into RGB.
// Stage 1 holds the pixel with the colormap it must use; stage 2 holds the
// mapped colour. The colormap is chosen at each accepted start-of-frame.
module gray_colormap
  import image_filter_pkg::*;
#(
  parameter int PIPE_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  gray_in,
  input  logic        in_sof,
  input  logic [1:0]  mode_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] pixel_out,
  output logic        out_sof
);

  if (PIPE_STAGES != 2) begin : g_bad_depth
    $error("gray_colormap only supports PIPE_STAGES = 2");
  end

  logic        v1;
  logic        sof1;
  logic [7:0]  gray1;
  cm_mode_t    mode1;
  cm_mode_t    mode_reg;
  cm_mode_t    mode_eff;
  logic        v2;
  logic        s1_adv;
  logic        s2_adv;
  logic        accept;
  logic [23:0] rgb1;

  // A stage may load when it is empty or its contents move on this cycle
  assign s2_adv   = !v2 || out_ready;
  assign s1_adv   = !v1 || s2_adv;
  assign in_ready = s1_adv;
  assign accept   = in_valid && s1_adv;
  assign mode_eff = in_sof ? cm_mode_t'(mode_in) : mode_reg;

  assign out_valid = v2;

  // Remember the frame's colormap; only a start-of-frame pixel changes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_reg <= CM_GRAY;
    end else if (accept && in_sof) begin
      mode_reg <= cm_mode_t'(mode_in);
    end
  end

  // Stage 1: capture the accepted pixel together with its effective mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      sof1  <= 1'b0;
      gray1 <= '0;
      mode1 <= CM_GRAY;
    end else if (s1_adv) begin
      v1 <= in_valid;
      if (in_valid) begin
        sof1  <= in_sof;
        gray1 <= gray_in;
        mode1 <= mode_eff;
      end
    end
  end

  colormap_lut u_lut (
    .gray (gray1),
    .mode (mode1),
    .rgb  (rgb1)
  );

  // Stage 2: register the mapped colour; held while downstream stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2        <= 1'b0;
      pixel_out <= '0;
      out_sof   <= 1'b0;
    end else if (s2_adv) begin
      v2 <= v1;
      if (v1) begin
        pixel_out <= rgb1;
        out_sof   <= sof1;
      end
    end
  end

endmodule

// File: tb/tb_gray_colormap.sv
// Self-checking bench for gray_colormap: directed colormap, stall and reset
// cases followed by a long randomized stream against a reference mapping.
module tb_gray_colormap;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  gray_in;
  logic        in_sof;
  logic [1:0]  mode_in;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] pixel_out;
  logic        out_sof;

  int checks = 0;
  int errors = 0;

  logic [24:0] expQ[$];
  logic [24:0] expEntry;
  int          modelMode = 0;
  int          acceptCount = 0;
  logic        prevStall = 1'b0;
  logic [23:0] prevPixel = '0;
  logic        prevSof = 1'b0;

  // Free-running clock, 10 time units per period
  always #5 clk = ~clk;

  gray_colormap #(.PIPE_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .gray_in   (gray_in),
    .in_sof    (in_sof),
    .mode_in   (mode_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pixel_out (pixel_out),
    .out_sof   (out_sof)
  );

  // Reference colour for a luminance under a colormap, from the mapping rules
  function automatic logic [23:0] refMap(input int g, input int mode);
    int r, gg, b;
    case (mode)
      1: begin
        r  = (3 * g > 255) ? 255 : 3 * g;
        gg = (g < 85) ? 0 : ((3 * (g - 85) > 255) ? 255 : 3 * (g - 85));
        b  = (g < 170) ? 0 : 3 * (g - 170);
      end
      2: begin
        r  = 255 - g;
        gg = 255 - g;
        b  = 255 - g;
      end
      3: begin
        r  = g;
        gg = (g * 7) / 8;
        b  = (g * 5) / 8;
      end
      default: begin
        r  = g;
        gg = g;
        b  = g;
      end
    endcase
    return 24'((r << 16) | (gg << 8) | b);
  endfunction

  // Count one comparison and report it when observed differs from expected
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Scoreboard: record accepted pixels, compare delivered ones, check holds
  always @(negedge clk) begin
    if (!rst_n) begin
      expQ.delete();
      modelMode = 0;
      prevStall = 1'b0;
    end else begin
      if (prevStall) begin
        checkOutput("hold_valid", out_valid, 1);
        checkOutput("hold_pixel", pixel_out, prevPixel);
        checkOutput("hold_sof", out_sof, prevSof);
      end
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("sb_unexpected_valid", out_valid, 0);
        end else begin
          expEntry = expQ.pop_front();
          checkOutput("sb_pixel", pixel_out, expEntry[23:0]);
          checkOutput("sb_sof", out_sof, expEntry[24]);
        end
      end
      if (in_valid && in_ready) begin
        if (in_sof) modelMode = int'(mode_in);
        expQ.push_back({in_sof, refMap(int'(gray_in), modelMode)});
        acceptCount++;
      end
      prevStall = out_valid && !out_ready;
      prevPixel = pixel_out;
      prevSof   = out_sof;
    end
  end

  // Send one pixel into an idle pipeline and check it emerges two cycles later
  task automatic applyStimulus(input logic [7:0] g, input logic sof,
                               input logic [1:0] mode, input logic [23:0] expected,
                               input string tag);
    in_valid = 1'b1;
    gray_in  = g;
    in_sof   = sof;
    mode_in  = mode;
    #1;
    checkOutput({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    checkOutput({tag, "_lat1"}, out_valid, 0);
    @(posedge clk); #1;
    checkOutput({tag, "_valid"}, out_valid, 1);
    checkOutput({tag, "_pixel"}, pixel_out, expected);
  endtask

  // Test sequence: reset, directed maps, stall, reset mid-flight, random
  initial begin
    logic       accepted;
    int         stallAcc;
    logic [7:0] nextG;
    int         cycles;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    gray_in   = '0;
    mode_in   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_pixel", pixel_out, 0);
    checkOutput("rst_out_sof", out_sof, 0);
    rst_n = 1'b1;
    #1;
    checkOutput("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    applyStimulus(8'd0,   1'b1, 2'd1, 24'h000000, "heat_0");
    applyStimulus(8'd84,  1'b0, 2'd1, 24'hFC0000, "heat_84");
    applyStimulus(8'd85,  1'b0, 2'd1, 24'hFF0000, "heat_85");
    applyStimulus(8'd128, 1'b0, 2'd1, 24'hFF8100, "heat_128");
    applyStimulus(8'd170, 1'b0, 2'd1, 24'hFFFF00, "heat_170");
    applyStimulus(8'd255, 1'b0, 2'd1, 24'hFFFFFF, "heat_255");
    applyStimulus(8'h3C,  1'b1, 2'd0, 24'h3C3C3C, "gray_3c");
    applyStimulus(8'd10,  1'b1, 2'd2, 24'hF5F5F5, "inv_sof");
    applyStimulus(8'd10,  1'b0, 2'd0, 24'hF5F5F5, "inv_nosof");
    applyStimulus(8'd200, 1'b1, 2'd3, 24'hC8AF7D, "sepia_200");
    repeat (2) @(posedge clk);
    #1;

    out_ready = 1'b0;
    nextG     = 8'h40;
    in_valid  = 1'b1;
    gray_in   = nextG;
    in_sof    = 1'b1;
    mode_in   = 2'd0;
    stallAcc  = 0;
    #1;
    for (int c = 0; c < 5; c++) begin
      if (c < 2) begin
        checkOutput("stall_ready_open", in_ready, 1);
      end else begin
        checkOutput("stall_ready_low", in_ready, 0);
        checkOutput("stall_pixel", pixel_out, 24'h404040);
      end
      accepted = in_ready;
      @(posedge clk); #1;
      if (accepted) begin
        stallAcc++;
        nextG   = nextG + 8'd1;
        gray_in = nextG;
        in_sof  = 1'b0;
      end
      #1;
    end
    checkOutput("stall_accepts", stallAcc, 2);
    out_ready = 1'b1;
    #1;
    for (int c = 0; c < 4; c++) begin
      accepted = in_ready;
      @(posedge clk); #1;
      if (accepted) begin
        nextG   = nextG + 8'd1;
        gray_in = nextG;
      end
      #1;
    end
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("stall_drain", expQ.size(), 0);

    out_ready = 1'b0;
    in_valid  = 1'b1;
    gray_in   = 8'h20;
    in_sof    = 1'b1;
    mode_in   = 2'd2;
    @(posedge clk); #1;
    gray_in = 8'h21;
    in_sof  = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1;
    checkOutput("rst_inflight_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async_valid", out_valid, 0);
    checkOutput("rst_async_pixel", pixel_out, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checkOutput("rst_release_ready", in_ready, 1);
    out_ready = 1'b1;
    applyStimulus(8'd10, 1'b0, 2'd2, 24'h0A0A0A, "post_rst_mode0");
    repeat (2) @(posedge clk);

    acceptCount = 0;
    cycles      = 0;
    while (acceptCount < 10000 && cycles < 60000) begin
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      gray_in   = 8'($urandom);
      in_sof    = ($urandom_range(0, 63) == 0);
      mode_in   = 2'($urandom);
      cycles++;
    end
    checkOutput("rand_accept_budget", acceptCount >= 10000, 1);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int w = 0; w < 20 && expQ.size() != 0; w++) @(posedge clk);
    #1;
    checkOutput("rand_drain", expQ.size(), 0);
    @(posedge clk); #1;
    checkOutput("final_out_valid", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
